// File: rtl/lsu_mem_port_if.sv
// Bundle of pipeline request/response and memory data-port signals around the LSU.
// master = pipeline plus memory side; slave = the load/store unit itself.
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask
    );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit driving the data port of a synchronous memory: byte masks,
// lane replication, load extraction with sign/zero extension, and a held response.
module lsu_mem_port #(
    parameter int READ_LATENCY = 1
) (
    input logic          clk,
    input logic          rst_n,
    lsu_mem_port_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [1:0]  off_reg, off_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;

    logic        accept;
    logic        access_err;
    logic        load_issue;
    logic        store_issue;
    logic [7:0]  rd_byte [4];
    logic [7:0]  wr_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;
    logic [3:0]  mask_raw;

    // Ready is gated by rst_n so nothing is accepted or strobed while reset is held.
    assign bus.req_ready = rst_n & (state_reg == IDLE);
    assign accept        = bus.req_valid & bus.req_ready;
    assign load_issue    = accept & ~bus.req_we & ~access_err;
    assign store_issue   = accept &  bus.req_we & ~access_err;

    assign bus.mem_addr  = {bus.req_addr[31:2], 2'b00};
    assign bus.mem_ren   = load_issue;
    assign bus.mem_wen   = store_issue;

    // Per-lane store replication and read-lane split.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = bus.mem_rdata[8*gi +: 8];
            assign wr_byte[gi] = (bus.req_funct3[1:0] == 2'd0) ? bus.req_wdata[7:0] :
                                 (bus.req_funct3[1:0] == 2'd1) ? bus.req_wdata[8*(gi%2) +: 8] :
                                                                 bus.req_wdata[8*gi +: 8];
            assign bus.mem_wdata[8*gi +: 8] = store_issue ? wr_byte[gi] : 8'h00;
        end
    endgenerate

    always_comb begin
        mask_raw = 4'b1111;
        case (bus.req_funct3[1:0])
            2'd0:    mask_raw = 4'b0001 << bus.req_addr[1:0];
            2'd1:    mask_raw = 4'b0011 << bus.req_addr[1:0];
            default: mask_raw = 4'b1111;
        endcase
    end

    assign bus.mem_mask = store_issue ? mask_raw : 4'b0000;

    // Alignment and encoding check for the request currently on the bus.
    always_comb begin
        access_err = 1'b0;
        if (bus.req_we) begin
            case (bus.req_funct3)
                3'd0:    access_err = 1'b0;
                3'd1:    access_err = bus.req_addr[0];
                3'd2:    access_err = |bus.req_addr[1:0];
                default: access_err = 1'b1;
            endcase
        end else begin
            case (bus.req_funct3)
                3'd0, 3'd4: access_err = 1'b0;
                3'd1, 3'd5: access_err = bus.req_addr[0];
                3'd2:       access_err = |bus.req_addr[1:0];
                default:    access_err = 1'b1;
            endcase
        end
    end

    // Lane extraction uses the funct3/offset captured at accept, not the live request.
    assign sel_byte = rd_byte[off_reg];
    assign sel_half = off_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_value = 32'h0;
        case (funct3_reg)
            3'd0:    load_value = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    load_value = {24'h0, sel_byte};
            3'd1:    load_value = {{16{sel_half[15]}}, sel_half};
            3'd5:    load_value = {16'h0, sel_half};
            3'd2:    load_value = bus.mem_rdata;
            default: load_value = 32'h0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        funct3_next = funct3_reg;
        off_next    = off_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (access_err) begin
                        state_next = RESP;
                        rdata_next = 32'h0;
                        err_next   = 1'b1;
                    end else if (bus.req_we) begin
                        state_next = RESP;
                        rdata_next = 32'h0;
                        err_next   = 1'b0;
                    end else begin
                        state_next  = WAIT;
                        cnt_next    = 3'd1;
                        funct3_next = bus.req_funct3;
                        off_next    = bus.req_addr[1:0];
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == LAT) begin
                    state_next = RESP;
                    rdata_next = load_value;
                    err_next   = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            funct3_reg <= 3'd0;
            off_reg    <= 2'd0;
            rdata_reg  <= 32'h0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            funct3_reg <= funct3_next;
            off_reg    <= off_next;
            rdata_reg  <= rdata_next;
            err_reg    <= err_next;
        end
    end

    assign bus.resp_valid = (state_reg == RESP);
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed and random accesses against a byte-array reference,
// plus a latency-3 instance driven cycle by cycle.
module tb_lsu_mem_port;

    localparam int RL = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_port_if b1 ();
    lsu_mem_port_if b3 ();

    lsu_mem_port #(.READ_LATENCY(RL)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    lsu_mem_port #(.READ_LATENCY(3))  dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    int errors = 0;
    int checks = 0;

    // Memory device seen by dut1: registered read, byte-masked write.
    logic [31:0] mem [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (b1.mem_wen) begin
            for (int i = 0; i < 4; i++)
                if (b1.mem_mask[i]) mem[b1.mem_addr[9:2]][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
        end
        if (b1.mem_ren) b1.mem_rdata <= mem[b1.mem_addr[9:2]];
    end

    // Reference model: plain byte array.
    logic [7:0] ref_mem [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic illegal;
        if (we) illegal = (f3 > 3'd2);
        else    illegal = (f3 == 3'd3) || (f3 >= 3'd6);
        return illegal || ((addr % size_of(f3)) != 0);
    endfunction

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input int off, input logic [31:0] word);
        int n;
        int k;
        logic [31:0] v;
        n = size_of(f3);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (f3 < 3'd4 && n < 4) begin
            k = 32 - 8*n;
            v = 32'($signed(v << k) >>> k);
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] word;
        int base;
        base = int'(addr[9:0]) & ~3;
        for (int i = 0; i < 4; i++) word[8*i +: 8] = ref_mem[base + i];
        return ref_extract(f3, int'(addr[1:0]), word);
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < size_of(f3); i++) ref_mem[int'(addr[9:0]) + i] = wdata[8*i +: 8];
    endtask

    // One full transaction on dut1; optional response stall with an intruding request.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int stall, input bit intrude,
                             output logic [31:0] rdata);
        logic        e;
        int          n;
        int          lat;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_mask;
        e        = ref_err(we, f3, addr);
        n        = size_of(f3);
        exp_rd   = (e || we) ? 32'h0 : ref_load(f3, addr);
        exp_mask = (!e && we) ? 4'(((1 << n) - 1) << addr[1:0]) : 4'h0;
        exp_wd   = 32'h0;
        if (!e && we) for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % n) +: 8];

        @(negedge clk);
        b1.req_valid  = 1'b1;
        b1.req_we     = we;
        b1.req_funct3 = f3;
        b1.req_addr   = addr;
        b1.req_wdata  = wdata;
        #1;
        check("req_ready_idle", 32'(b1.req_ready), 32'd1);
        check("mem_ren", 32'(b1.mem_ren), 32'(!e && !we));
        check("mem_wen", 32'(b1.mem_wen), 32'(!e && we));
        check("mem_mask", 32'(b1.mem_mask), 32'(exp_mask));
        check("mem_addr", b1.mem_addr, {addr[31:2], 2'b00});
        if (!e && we) check("mem_wdata", b1.mem_wdata, exp_wd);
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        if (!e && we) ref_store(f3, addr, wdata);

        exp_lat = (e || we) ? 1 : RL + 1;
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
        end while (!b1.resp_valid && lat < 12);
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(b1.resp_err), 32'(e));
        check("resp_rdata", b1.resp_rdata, exp_rd);
        rdata = b1.resp_rdata;

        for (int s = 0; s < stall; s++) begin
            if (intrude) begin
                b1.req_valid  = 1'b1;
                b1.req_we     = 1'b1;
                b1.req_funct3 = 3'd2;
                b1.req_addr   = 32'h104;
                b1.req_wdata  = $urandom;
                #1;
                check("stall_no_wen", 32'(b1.mem_wen), 32'd0);
            end
            check("stall_req_ready", 32'(b1.req_ready), 32'd0);
            @(negedge clk);
            #1;
            check("stall_valid", 32'(b1.resp_valid), 32'd1);
            check("stall_rdata", b1.resp_rdata, exp_rd);
            check("stall_err", 32'(b1.resp_err), 32'(e));
        end

        b1.req_valid  = 1'b0;
        b1.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        b1.resp_ready = 1'b0;
        check("post_hs_valid", 32'(b1.resp_valid), 32'd0);
        check("post_hs_rdata", b1.resp_rdata, exp_rd);
        check("post_hs_ready", 32'(b1.req_ready), 32'd1);
        $display("txn we=%0d f3=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d stall=%0d",
                 we, f3, addr, wdata, e, rdata, lat, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] words [4];
        logic [2:0]  f3_tab [5];
        logic [2:0]  f3;
        int          off;
        int          n;

        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        b1.req_valid = 0; b1.req_we = 0; b1.req_funct3 = 0; b1.req_addr = 0; b1.req_wdata = 0;
        b1.resp_ready = 0;
        b3.req_valid = 0; b3.req_we = 0; b3.req_funct3 = 0; b3.req_addr = 0; b3.req_wdata = 0;
        b3.resp_ready = 0; b3.mem_rdata = 0;

        // Reset state
        #3 rst_n = 1'b0;
        b1.req_valid = 1'b1;
        #1;
        check("rst_resp_valid", 32'(b1.resp_valid), 32'd0);
        check("rst_resp_rdata", b1.resp_rdata, 32'h0);
        check("rst_resp_err", 32'(b1.resp_err), 32'd0);
        check("rst_req_ready", 32'(b1.req_ready), 32'd0);
        check("rst_mem_ren", 32'(b1.mem_ren), 32'd0);
        b1.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence
        do_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1'b0, rd);
        do_access(1'b0, 3'd2, 32'h100, 32'h0, 0, 1'b0, rd);
        check("lw_literal", rd, 32'hDEADBEEF);
        do_access(1'b1, 3'd0, 32'h103, 32'h80, 0, 1'b0, rd);
        do_access(1'b0, 3'd0, 32'h103, 32'h0, 0, 1'b0, rd);
        check("lb_literal", rd, 32'hFFFFFF80);
        do_access(1'b0, 3'd4, 32'h103, 32'h0, 0, 1'b0, rd);
        check("lbu_literal", rd, 32'h00000080);
        do_access(1'b1, 3'd1, 32'h102, 32'h8001, 0, 1'b0, rd);
        do_access(1'b0, 3'd1, 32'h102, 32'h0, 0, 1'b0, rd);
        check("lh_literal", rd, 32'hFFFF8001);
        do_access(1'b0, 3'd5, 32'h102, 32'h0, 0, 1'b0, rd);
        check("lhu_literal", rd, 32'h00008001);
        do_access(1'b0, 3'd1, 32'h101, 32'h0, 0, 1'b0, rd);
        do_access(1'b0, 3'd2, 32'h100, 32'h0, 5, 1'b1, rd);
        check("bp_literal", rd, 32'h8001BEEF);

        // Reset during WAIT of a load
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_funct3 = 3'd2; b1.req_addr = 32'h100;
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        b1.req_valid = 1'b1;
        #1;
        check("midrst_valid", 32'(b1.resp_valid), 32'd0);
        check("midrst_ready", 32'(b1.req_ready), 32'd0);
        check("midrst_ren", 32'(b1.mem_ren), 32'd0);
        b1.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("postrst_no_resp", 32'(b1.resp_valid), 32'd0);
            check("postrst_ready", 32'(b1.req_ready), 32'd1);
        end

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      32'($urandom_range(0, 1023)), $urandom,
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd);
        end

        // Latency-3 instance: result must come from the word present in cycle 3
        for (int t = 0; t < 5; t++) begin
            f3  = f3_tab[$urandom_range(0, 4)];
            n   = size_of(f3);
            off = ($urandom_range(0, 3) / n) * n;
            @(negedge clk);
            b3.req_valid  = 1'b1;
            b3.req_we     = 1'b0;
            b3.req_funct3 = f3;
            b3.req_addr   = 32'h200 | 32'(off);
            #1;
            check("rl3_ren", 32'(b3.mem_ren), 32'd1);
            @(posedge clk);
            #1;
            b3.req_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                words[c] = $urandom;
                b3.mem_rdata = words[c];
                #1;
                check("rl3_not_yet", 32'(b3.resp_valid), 32'd0);
            end
            @(negedge clk);
            b3.mem_rdata = $urandom;
            #1;
            check("rl3_valid", 32'(b3.resp_valid), 32'd1);
            check("rl3_rdata", b3.resp_rdata, ref_extract(f3, off, words[3]));
            b3.resp_ready = 1'b1;
            @(negedge clk);
            #1;
            b3.resp_ready = 1'b0;
            check("rl3_hs", 32'(b3.resp_valid), 32'd0);
            $display("txn rl3 f3=%0d off=%0d word=%h -> rdata=%h", f3, off, words[3], b3.resp_rdata);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
